// File: rtl/dmem_pkg.sv
// Shared types, func3 codes and byte-enable helper for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } dmem_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Lane mask for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_en(input logic [2:0] func3, input logic [1:0] addr);
        logic [3:0] be;
        be = '0;
        case (func3)
            F3_B:    be = 4'b0001 << addr;
            F3_H:    be = addr[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = '1;
            default: be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/halfword/word from a memory word and sign- or zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = word >> {addr, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr[1] ? word[31:16] : word[15:0];
        data    = '0;
        case (func3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h000000, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0000, half_v};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: valid/ready request, programmable wait states,
// byte-enable store merge, formatted load data and alignment/legality checking.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rdata,
    output logic                  resp_valid,
    output logic                  err,
    output logic                  mem_stall
);

    localparam int WORDS = 2 ** (DM_ADDRESS - 2);

    logic [DATA_W-1:0]     mem [WORDS];

    dmem_state_e           state, state_n;
    logic [3:0]            cnt;
    logic                  op_rd, op_wr;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            f3_q;
    logic                  err_q;
    logic [DATA_W-1:0]     rdata_q;

    logic                  accept;
    logic                  illegal;
    logic                  bad_f3;
    logic                  misaligned;
    logic                  last_access;
    logic [3:0]            be;
    logic [DATA_W-1:0]     wmerge;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     load_data;

    always_comb begin
        accept = (state == IDLE) && req_valid && (MemRead || MemWrite);
        if (MemRead)
            bad_f3 = (func3 == 3'd3) || (func3 == 3'd6) || (func3 == 3'd7);
        else
            bad_f3 = (func3 > F3_W);
        misaligned = ((func3[1:0] == 2'd1) && addr[0]) ||
                     ((func3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
        illegal    = (MemRead && MemWrite) || bad_f3 || misaligned;
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        mem_stall  = 1'b0;
        resp_valid = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    mem_stall = 1'b1;
                    state_n   = illegal ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                if (cnt == '0)
                    state_n = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                err        = err_q;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        last_access = (state == ACCESS) && (cnt == '0);
        be          = byte_en(f3_q, addr_q[1:0]);
        case (f3_q[1:0])
            2'd0:    wmerge = {4{wdata_q[7:0]}};
            2'd1:    wmerge = {2{wdata_q[15:0]}};
            default: wmerge = wdata_q;
        endcase
        rd_word = mem[addr_q[DM_ADDRESS-1:2]];
    end

    dmem_load_align u_align (
        .word  (rd_word),
        .addr  (addr_q[1:0]),
        .func3 (f3_q),
        .data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_rd   <= MemRead;
                op_wr   <= MemWrite;
                addr_q  <= addr;
                wdata_q <= wdata;
                f3_q    <= func3;
                err_q   <= illegal;
                cnt     <= 4'(WAIT_CYCLES);
                // Rejected requests respond next cycle, so clear the data now.
                if (illegal)
                    rdata_q <= '0;
            end else if (state == ACCESS) begin
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                else
                    rdata_q <= op_rd ? load_data : '0;
            end
        end
    end

    // Storage has no reset; a reset in the final access cycle must still suppress the write.
    always_ff @(posedge clk) begin
        if (!reset && last_access && op_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i])
                    mem[addr_q[DM_ADDRESS-1:2]][8*i +: 8] <= wmerge[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: byte-array memory model plus per-cycle output comparison.
module tb_dmem_responder;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, MemRead, MemWrite;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic        req_ready, resp_valid, err, mem_stall;
    logic [31:0] rdata;

    logic        r3_valid, r3_rd, r3_wr;
    logic [8:0]  r3_addr;
    logic [31:0] r3_wdata;
    logic [2:0]  r3_f3;
    logic        o3_ready, o3_rv, o3_err, o3_stall;
    logic [31:0] o3_rdata;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    logic [7:0]  mem_m [512];
    logic        chk_en = 1'b0;
    logic        active = 1'b0;
    int          t_acc, t_resp;
    logic        txn_err;
    logic [31:0] old_rd = '0;
    logic [31:0] new_rd = '0;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata),
        .func3(func3), .rdata(rdata), .resp_valid(resp_valid), .err(err),
        .mem_stall(mem_stall)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .req_valid(r3_valid), .req_ready(o3_ready),
        .MemRead(r3_rd), .MemWrite(r3_wr), .addr(r3_addr), .wdata(r3_wdata),
        .func3(r3_f3), .rdata(o3_rdata), .resp_valid(o3_rv), .err(o3_err),
        .mem_stall(o3_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, got, exp);
        end
    endtask

    // Reference behaviour on a byte-addressed memory.
    task automatic model(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d,
                         input logic [2:0] f, output logic e, output logic [31:0] r);
        int b;
        logic half, word;
        b    = int'(a);
        half = (f == 3'd1) || (f == 3'd5);
        word = (f == 3'd2);
        e = (rd && wr) || (rd && (f == 3'd3 || f >= 3'd6)) || (!rd && f > 3'd2) ||
            (half && a[0]) || (word && a[1:0] != 2'b00);
        r = '0;
        if (!e && rd) begin
            case (f)
                3'd0: r = {{24{mem_m[b][7]}}, mem_m[b]};
                3'd4: r = {24'h0, mem_m[b]};
                3'd1: r = {{16{mem_m[b+1][7]}}, mem_m[b+1], mem_m[b]};
                3'd5: r = {16'h0, mem_m[b+1], mem_m[b]};
                default: r = {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
            endcase
        end else if (!e && wr) begin
            mem_m[b] = d[7:0];
            if (f != 3'd0) mem_m[b+1] = d[15:8];
            if (f == 3'd2) begin
                mem_m[b+2] = d[23:16];
                mem_m[b+3] = d[31:24];
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("resp_valid", 32'(resp_valid), 32'(active && cyc == t_resp));
            chk("err",        32'(err),        32'(active && cyc == t_resp && txn_err));
            chk("mem_stall",  32'(mem_stall),  32'(active && cyc >= t_acc && cyc < t_resp));
            chk("req_ready",  32'(req_ready),  32'(!(active && cyc > t_acc && cyc <= t_resp)));
            chk("rdata",      rdata,           (active && cyc >= t_resp) ? new_rd : old_rd);
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d,
                          input logic [2:0] f, output logic [31:0] got, output logic gerr,
                          output int lat);
        logic        e;
        logic [31:0] r;
        logic        seen;
        model(rd, wr, a, d, f, e, r);
        t_acc   = cyc;
        t_resp  = cyc + (e ? 1 : W + 2);
        txn_err = e;
        new_rd  = r;
        active  = 1'b1;
        req_valid = 1'b1; MemRead = rd; MemWrite = wr; addr = a; wdata = d; func3 = f;
        seen = 1'b0; got = '0; gerr = 1'b0; lat = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1; got = rdata; gerr = err; lat = cyc - t_acc;
            end
        end
        if (!seen) begin
            vectors++; fails++;
            $display("FAIL timeout: no resp_valid within 40 cycles of cycle %0d", t_acc);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        active = 1'b0;
        old_rd = new_rd;
    endtask

    task automatic u3_req(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d,
                          input logic [2:0] f, output int nstall, output int first,
                          output int resp_at, output logic [31:0] rdat, output logic rerr);
        int t0;
        t0 = cyc;
        r3_valid = 1'b1; r3_rd = rd; r3_wr = wr; r3_addr = a; r3_wdata = d; r3_f3 = f;
        nstall = 0; first = -1; resp_at = -1; rdat = '0; rerr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o3_stall) begin
                nstall++;
                if (first < 0) first = cyc - t0;
            end
            if (o3_rv && resp_at < 0) begin
                resp_at = cyc - t0; rdat = o3_rdata; rerr = o3_err;
            end
            @(posedge clk); #1;
            if (resp_at >= 0) begin
                r3_valid = 1'b0; r3_rd = 1'b0; r3_wr = 1'b0;
            end else begin
                // Scramble everything mid-access; the responder must use latched values.
                r3_valid = 1'($urandom_range(0, 1));
                r3_addr  = 9'($urandom);
                r3_wdata = $urandom;
            end
        end
    endtask

    initial begin
        logic [31:0] g;
        logic        ge;
        int          lat, ns, fs, ra;
        logic        rd, wr;
        logic [2:0]  f;
        logic [8:0]  a;
        int          k;

        reset = 1'b1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0; func3 = '0;
        r3_valid = 1'b0; r3_rd = 1'b0; r3_wr = 1'b0; r3_addr = '0; r3_wdata = '0; r3_f3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rv",    32'(resp_valid), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst3_ready", 32'(o3_ready), 32'd1);
        @(posedge clk); #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        for (int w = 0; w < 128; w++)
            do_req(1'b0, 1'b1, 9'(w * 4), $urandom, 3'd2, g, ge, lat);

        do_req(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2, g, ge, lat);
        chk("sw_lat", 32'(lat), 32'd3);
        chk("sw_err", 32'(ge), 32'd0);
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'd2, g, ge, lat);
        chk("lw_deadbeef", g, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, 9'h010, 32'h11223344, 3'd2, g, ge, lat);
        do_req(1'b0, 1'b1, 9'h013, 32'h000000A5, 3'd0, g, ge, lat);
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'd2, g, ge, lat);
        chk("sb_merge", g, 32'hA5223344);
        do_req(1'b1, 1'b0, 9'h013, 32'h0, 3'd0, g, ge, lat);
        chk("lb_sext", g, 32'hFFFFFFA5);
        do_req(1'b1, 1'b0, 9'h013, 32'h0, 3'd4, g, ge, lat);
        chk("lbu_zext", g, 32'h000000A5);

        do_req(1'b0, 1'b1, 9'h020, 32'hCAFE1234, 3'd2, g, ge, lat);
        do_req(1'b0, 1'b1, 9'h022, 32'h00008001, 3'd1, g, ge, lat);
        do_req(1'b1, 1'b0, 9'h022, 32'h0, 3'd1, g, ge, lat);
        chk("lh_sext", g, 32'hFFFF8001);
        do_req(1'b1, 1'b0, 9'h022, 32'h0, 3'd5, g, ge, lat);
        chk("lhu_zext", g, 32'h00008001);
        do_req(1'b1, 1'b0, 9'h020, 32'h0, 3'd5, g, ge, lat);
        chk("lo_half_kept", g, 32'h00001234);

        do_req(1'b1, 1'b0, 9'h011, 32'h0, 3'd2, g, ge, lat);
        chk("mis_lw_err", 32'(ge), 32'd1);
        chk("mis_lw_lat", 32'(lat), 32'd1);
        chk("mis_lw_rdata", g, 32'd0);
        do_req(1'b1, 1'b0, 9'h023, 32'h0, 3'd1, g, ge, lat);
        chk("mis_lh_err", 32'(ge), 32'd1);
        do_req(1'b1, 1'b1, 9'h010, 32'hFFFFFFFF, 3'd2, g, ge, lat);
        chk("both_err", 32'(ge), 32'd1);
        do_req(1'b0, 1'b1, 9'h021, 32'hFFFFFFFF, 3'd1, g, ge, lat);
        chk("mis_sh_err", 32'(ge), 32'd1);
        do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'd2, g, ge, lat);
        chk("mem_unchanged", g, 32'hA5223344);
        do_req(1'b1, 1'b0, 9'h020, 32'h0, 3'd2, g, ge, lat);
        chk("mem_unchanged2", g, 32'h80011234);

        // Reset lands on the final access cycle of a store.
        do_req(1'b0, 1'b1, 9'h030, 32'h0BADF00D, 3'd2, g, ge, lat);
        chk_en = 1'b0;
        req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; addr = 9'h030;
        wdata = 32'h12345678; func3 = 3'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; MemWrite = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_rv",    32'(resp_valid), 32'd0);
        chk("rstmid_err",   32'(err), 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        chk("rstmid_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        old_rd = '0;
        chk_en = 1'b1;
        do_req(1'b1, 1'b0, 9'h030, 32'h0, 3'd2, g, ge, lat);
        chk("rstmid_nowrite", g, 32'h0BADF00D);

        u3_req(1'b0, 1'b1, 9'h040, 32'h5A5AC3C3, 3'd2, ns, fs, ra, g, ge);
        chk("w3_stall_cnt", 32'(ns), 32'd5);
        chk("w3_stall_first", 32'(fs), 32'd0);
        chk("w3_resp_at", 32'(ra), 32'd5);
        chk("w3_err", 32'(ge), 32'd0);
        u3_req(1'b1, 1'b0, 9'h040, 32'h0, 3'd2, ns, fs, ra, g, ge);
        chk("w3_ld_stall", 32'(ns), 32'd5);
        chk("w3_ld_resp", 32'(ra), 32'd5);
        chk("w3_ld_data", g, 32'h5A5AC3C3);
        u3_req(1'b1, 1'b0, 9'h041, 32'h0, 3'd1, ns, fs, ra, g, ge);
        chk("w3_err_resp", 32'(ra), 32'd1);
        chk("w3_err_flag", 32'(ge), 32'd1);
        chk("w3_err_stall", 32'(ns), 32'd1);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 19);
            rd = (k < 9) || (k >= 18);
            wr = (k >= 9);
            f  = 3'($urandom_range(0, 7));
            a  = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'd1) a[0] = 1'b0;
                if (f[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            do_req(rd, wr, a, $urandom, f, g, ge, lat);
            repeat ($urandom_range(0, 2)) begin
                req_valid = 1'($urandom_range(0, 1));
                MemRead = 1'b0; MemWrite = 1'b0;
                addr = 9'($urandom);
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
